// File: rtl/iomem_timer.sv
// Memory-mapped countdown timer on the iomem bus: prescaler, optional auto-reload
// and a level interrupt (EXPIRED & IRQ_EN). Bus accesses are acknowledged one cycle after they execute.
module iomem_timer #(
    parameter logic [23:0] BASE_HI = 24'h030001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic [15:0] pre_q, pre_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    logic        exec, reg_hit, wr;
    logic [2:0]  idx;
    logic        wr_ctrl, wr_pre, wr_load, wr_status, clr_exp;
    logic        run, tick, expire;
    logic [31:0] rd_val;
    logic        unused_addr;

    assign unused_addr = ^iomem_addr[1:0];

    // Handshake: an access executes when valid, selected and not already acknowledging;
    // ready then pulses for one cycle alongside rdata, so valid may stay high through it.
    always_comb begin
        exec      = iomem_valid && !ready_q && (iomem_addr[31:8] == BASE_HI);
        reg_hit   = exec && (iomem_addr[7:5] == 3'd0);
        idx       = iomem_addr[4:2];
        wr        = reg_hit && (iomem_wstrb != 4'd0);
        wr_ctrl   = wr && (idx == 3'd0);
        wr_pre    = wr && (idx == 3'd1);
        wr_load   = wr && (idx == 3'd2);
        wr_status = wr && (idx == 3'd3);
        clr_exp   = wr_status && iomem_wstrb[0] && iomem_wdata[0];

        rd_val = 32'd0;
        if (iomem_addr[7:5] == 3'd0) begin
            case (idx)
                3'd0:    rd_val = {29'd0, ctrl_q};
                3'd1:    rd_val = {16'd0, prescale_q};
                3'd2:    rd_val = load_q;
                3'd3:    rd_val = {31'd0, expired_q};
                3'd4:    rd_val = count_q;
                default: rd_val = 32'd0;
            endcase
        end

        ctrl_d = ctrl_q;
        if (wr_ctrl && iomem_wstrb[0]) ctrl_d = iomem_wdata[2:0];

        prescale_d = prescale_q;
        if (wr_pre && iomem_wstrb[0]) prescale_d[7:0]  = iomem_wdata[7:0];
        if (wr_pre && iomem_wstrb[1]) prescale_d[15:8] = iomem_wdata[15:8];

        load_d = load_q;
        for (int b = 0; b < 4; b++) begin
            if (wr_load && iomem_wstrb[b]) load_d[b*8 +: 8] = iomem_wdata[b*8 +: 8];
        end

        run  = ctrl_q[0] && (count_q != 32'd0);
        tick = run && (pre_q == prescale_q);

        pre_d = pre_q;
        if (!ctrl_q[0])  pre_d = 16'd0;
        else if (run)    pre_d = tick ? 16'd0 : pre_q + 16'd1;

        count_d = count_q;
        expire  = 1'b0;
        if (tick) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else begin
                expire  = 1'b1;
                count_d = ctrl_q[1] ? load_q : 32'd0;
            end
        end
        // A LOAD write overrides any tick landing on the same edge, expiry included.
        if (wr_load) begin
            count_d = load_d;
            pre_d   = 16'd0;
            expire  = 1'b0;
        end

        expired_d = expired_q;
        if (clr_exp) expired_d = 1'b0;
        if (expire)  expired_d = 1'b1;

        ready_d = exec;
        rdata_d = exec ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q     <= 3'd0;
            prescale_q <= 16'd0;
            load_q     <= 32'd0;
            count_q    <= 32'd0;
            expired_q  <= 1'b0;
            pre_q      <= 16'd0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            pre_q      <= pre_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = expired_q & ctrl_q[2];
endmodule

// File: tb/tb_iomem_timer.sv
// Bench for iomem_timer: behavioural model predicts read data into a queue that a
// monitor drains on every ready; ready and irq are checked cycle by cycle.
module tb_iomem_timer;
    localparam logic [31:0] BASE = 32'h0300_0100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        irq;

    iomem_timer dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Reference model state: programmer-visible registers plus clocks elapsed toward the next tick
    logic [2:0]  m_ctrl;
    logic [15:0] m_presc;
    logic [15:0] m_elapsed;
    logic [31:0] m_load;
    logic [31:0] m_count;
    logic        m_exp;
    logic        m_ready;
    int          cyc;
    int          load_cyc;

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_presc = 0; m_elapsed = 0; m_load = 0;
        m_count = 0; m_exp = 0; m_ready = 0;
    endtask

    // Advances the model across one rising edge using the bus inputs held during the cycle.
    task automatic model_edge();
        logic exec, hit, wr, tick, expire;
        logic [2:0]  idx;
        logic [31:0] rd;
        logic [31:0] regs [0:7];
        cyc++;
        exec = iomem_valid && (iomem_addr[31:8] == BASE[31:8]) && !m_ready;
        hit  = exec && (iomem_addr[7:5] == 3'd0);
        idx  = iomem_addr[4:2];
        wr   = hit && (iomem_wstrb != 4'd0);
        regs[0] = {29'd0, m_ctrl};
        regs[1] = {16'd0, m_presc};
        regs[2] = m_load;
        regs[3] = {31'd0, m_exp};
        regs[4] = m_count;
        regs[5] = 0; regs[6] = 0; regs[7] = 0;
        rd = hit ? regs[idx] : 32'd0;
        if (exec) exp_q.push_back(rd);

        // One tick every PRESCALE+1 enabled clocks while COUNT is non-zero
        tick = 1'b0;
        if (!m_ctrl[0]) m_elapsed = 0;
        else if (m_count != 0) begin
            if (m_elapsed == m_presc) begin
                tick = 1'b1;
                m_elapsed = 0;
            end else begin
                m_elapsed = m_elapsed + 16'd1;
            end
        end

        expire = 1'b0;
        if (wr && idx == 3'd2) begin
            for (int b = 0; b < 4; b++)
                if (iomem_wstrb[b]) m_load[b*8 +: 8] = iomem_wdata[b*8 +: 8];
            m_count   = m_load;
            m_elapsed = 0;
            load_cyc  = cyc;
        end else if (tick) begin
            if (m_count == 1) begin
                expire  = 1'b1;
                m_count = m_ctrl[1] ? m_load : 32'd0;
            end else begin
                m_count = m_count - 1;
            end
        end

        if (wr && idx == 3'd0 && iomem_wstrb[0]) m_ctrl = iomem_wdata[2:0];
        if (wr && idx == 3'd1 && iomem_wstrb[0]) m_presc[7:0]  = iomem_wdata[7:0];
        if (wr && idx == 3'd1 && iomem_wstrb[1]) m_presc[15:8] = iomem_wdata[15:8];
        if (wr && idx == 3'd3 && iomem_wstrb[0] && iomem_wdata[0]) m_exp = 1'b0;
        if (expire) m_exp = 1'b1;
        m_ready = exec;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("ready", {31'd0, iomem_ready}, {31'd0, m_ready});
        check("irq", {31'd0, irq}, {31'd0, m_exp & m_ctrl[2]});
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        step();
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        step();
    endtask

    task automatic rd(input logic [7:0] off);
        access(BASE + {24'd0, off}, 32'd0, 4'd0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        access(BASE + {24'd0, off}, d, 4'hF);
    endtask

    // Monitor: every acknowledge must match the oldest predicted read value
    always @(negedge clk) begin
        if (resetn && iomem_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rdata: unexpected ready, got 0x%08h expected no response", iomem_rdata);
            end else begin
                check("rdata", iomem_rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        logic [2:0]  ridx;
        logic [7:0]  off;
        logic [31:0] d;
        logic [3:0]  s;

        resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 0; iomem_addr = 0; iomem_wdata = 0;
        cyc = 0; load_cyc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, iomem_ready}, 32'd0);
        check("reset_rdata", iomem_rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;

        // All registers read zero after reset
        for (int i = 0; i < 8; i++) rd(8'(i * 4));

        // PRESCALE=3, LOAD=5: expiry 20 clocks after the LOAD write
        wr(8'h04, 32'd3);
        wr(8'h00, 32'h5);
        wr(8'h08, 32'd5);
        got = -1;
        for (int i = 0; i < 60; i++) begin
            if (irq) begin
                got = cyc - load_cyc;
                break;
            end
            step();
        end
        check("expiry_interval", got, 32'd20);
        rd(8'h10);
        repeat (10) step();
        rd(8'h10);
        rd(8'h0C);

        // Auto-reload every 2 clocks; a clear landing on an expiry edge loses
        wr(8'h0C, 32'd1);
        wr(8'h04, 32'd0);
        wr(8'h00, 32'h7);
        wr(8'h08, 32'd2);
        for (int i = 0; i < 6; i++) begin
            rd(8'h10);
            rd(8'h0C);
            step();
        end
        for (int i = 0; i < 10 && m_count != 1; i++) step();
        wr(8'h0C, 32'd1);
        check("clear_vs_expiry_irq", {31'd0, irq}, 32'd1);
        rd(8'h0C);

        // Byte-strobed LOAD write also lands in COUNT
        wr(8'h00, 32'h0);
        wr(8'h08, 32'h1122_3344);
        access(BASE + 32'h08, 32'h0000_AB00, 4'b0010);
        rd(8'h08);
        rd(8'h10);

        // Outside the window: never acknowledged
        iomem_valid = 1'b1; iomem_addr = 32'h0300_0004; iomem_wdata = 32'hFFFF_FFFF; iomem_wstrb = 4'hF;
        repeat (10) step();
        iomem_valid = 1'b0; iomem_wstrb = 0;
        step();
        // Unmapped offset inside the window: acknowledged, reads 0, no side effects
        rd(8'h18);
        wr(8'h18, 32'hFFFF_FFFF);
        rd(8'h40);
        for (int i = 0; i < 5; i++) rd(8'(i * 4));

        // Randomised traffic with small values so the timer stays active
        wr(8'h04, 32'd1);
        for (int n = 0; n < 150; n++) begin
            ridx = 3'($urandom_range(0, 7));
            off  = ($urandom_range(0, 15) == 0) ? 8'h40 : {3'd0, ridx, 2'd0};
            s    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
            case (ridx)
                3'd0:    d = 32'($urandom_range(0, 7));
                3'd1:    d = 32'($urandom_range(0, 2));
                3'd2:    d = 32'($urandom_range(0, 6));
                3'd3:    d = 32'($urandom_range(0, 1));
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) s = 4'd0;
            access(BASE + {24'd0, off}, d, s);
            repeat ($urandom_range(0, 3)) step();
        end

        // Reset with an access in flight while the interrupt is asserted
        wr(8'h0C, 32'd1);
        wr(8'h04, 32'd0);
        wr(8'h00, 32'h7);
        wr(8'h08, 32'd3);
        for (int i = 0; i < 10 && !irq; i++) step();
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        iomem_valid = 1'b1; iomem_addr = BASE + 32'h10; iomem_wstrb = 0;
        @(posedge clk);
        model_edge();
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_ready", {31'd0, iomem_ready}, 32'd0);
        check("async_reset_rdata", iomem_rdata, 32'd0);
        check("async_reset_irq", {31'd0, irq}, 32'd0);
        exp_q.delete();
        model_reset();
        iomem_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (5) step();
        rd(8'h0C);
        rd(8'h10);
        rd(8'h00);

        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped countdown timer for the SoC's iomem expansion bus, with a prescaler, optional auto-reload and a level interrupt. It sits downstream of the SoC's iomem master port, decoding its own address window beside the board-level GPIO register. Its `irq` output drives one of the SoC's spare external interrupt inputs (irq_5).

## Interface

Parameters:
- `BASE_HI`, default 24'h030001: block selected when `iomem_addr[31:8] == BASE_HI`, giving window 0x0300_0100–0x0300_01FF.

Ports:
- `clk` in 1: single clock; every flop uses it.
- `resetn` in 1: reset, asynchronous and active-low.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: registered one-cycle acknowledge.
- `iomem_wstrb` in 4: byte write strobes; 0 = read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: registered read data.
- `irq` out 1: level interrupt, `EXPIRED & IRQ_EN`.

## Operation

- Register map, decoded on `addr[4:2]` inside the window:
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; other bits read 0.
  - 0x04 PRESCALE: [15:0]; one tick every PRESCALE+1 clocks.
  - 0x08 LOAD: 32-bit. Any write also copies the new LOAD into COUNT and clears the prescaler.
  - 0x0C STATUS: [0] EXPIRED, sticky. Writing 1 to byte 0 bit 0 clears it.
  - 0x10 COUNT: read-only; writes ignored.
  - 0x14–0x1C and the rest of the window: read 0, writes ignored, still acknowledged.
- Writes honour `wstrb` per byte. The LOAD-to-COUNT copy uses the merged post-strobe LOAD value.
- Read data is the register value before any same-cycle write.
- Prescaler:
  - Counter `pre` [15:0] runs while EN=1 and COUNT != 0.
  - When `pre == PRESCALE`, `pre` goes to 0 and a tick is generated; otherwise `pre` increments.
  - While EN=0, `pre` is held at 0.
- On a tick:
  - COUNT > 1: COUNT decrements.
  - COUNT == 1: EXPIRED is set. COUNT becomes LOAD if AUTO_RELOAD=1, else 0.
- COUNT == 0 with EN=1: the timer is idle, with no ticks and no expiry.
- AUTO_RELOAD with LOAD=0: expires once, then sits idle at 0.
- Simultaneous events:
  - Expiry and a STATUS clear in the same cycle: EXPIRED stays 1.
  - A LOAD write and a tick in the same cycle: the write wins. COUNT = new LOAD, `pre` = 0, and the tick is discarded with no expiry.
  - A CTRL write that clears EN in the same cycle as a tick: the tick still applies, then the timer freezes.
- Reset mid-operation: all state cleared immediately and asynchronously. Any in-flight access is dropped, with no ready.

## Timing

- Reset values: `iomem_ready`=0, `iomem_rdata`=0, `irq`=0, CTRL=0, PRESCALE=0, LOAD=0, COUNT=0, EXPIRED=0, `pre`=0.
- Handshake:
  - An access executes in the cycle where `iomem_valid && !iomem_ready && selected` is true.
  - `iomem_ready` goes high the following cycle for exactly one cycle, together with `iomem_rdata`.
  - Each access therefore has latency 1, and back-to-back accesses are spaced 2 cycles apart.
- Unselected addresses: `iomem_ready` stays 0 and `iomem_rdata` holds its value.
- Register writes take effect in the cycle after the execute edge.
- Expiry interval with EN=1: (PRESCALE+1) × LOAD clocks from the LOAD write to EXPIRED=1.
- `irq` is combinational from flops. It rises in the same cycle EXPIRED reads 1 and falls the cycle after the clearing write executes.

## Test plan

- Reset, then read each register -> all read 0; `irq`=0; `iomem_ready` pulses exactly 1 cycle, 1 cycle after `valid`.
- PRESCALE=3, LOAD=5, CTRL=0x5 -> EXPIRED and `irq` go high exactly 20 clocks after the LOAD write; COUNT reads 0 afterwards and stays 0.
- CTRL=0x7, PRESCALE=0, LOAD=2 -> EXPIRED every 2 clocks with COUNT cycling 2,1,2. Clearing STATUS on an expiry cycle leaves EXPIRED=1.
- Byte write of LOAD with wstrb=4'b0010 and wdata=0x0000AB00 over LOAD=0x11223344 -> LOAD=0x1122AB44, and COUNT=0x1122AB44 on the next read.
- Address 0x0300_0004 (outside the window) -> no `ready` for 10 cycles. Address 0x0300_0118 -> `ready` returned, read data 0, no state change.
- Assert `resetn` low mid-count with a pending access -> every output is 0 within the same cycle; no `ready` is issued after release.
